// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_pkg;

  localparam int FRAME_BITS = 8;
  localparam logic [FRAME_BITS-1:0] DEFAULT_IDLE_BYTE = 8'h00;

  typedef enum logic {
    IDLE,
    SHIFT
  } spiState_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with registered
// single-cycle rise/fall pulses taken from the last two stages.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              rise_q;
  logic              fall_q;

  // Edge pulses are built from the two oldest stages, so a pulse is valid
  // on the same edge the synchronized level changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= {STAGES{RESET_VAL}};
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
      rise_q  <= chain_q[STAGES-2] & ~chain_q[STAGES-1];
      fall_q  <= ~chain_q[STAGES-2] & chain_q[STAGES-1];
    end
  end

  assign q_o    = chain_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target: oversamples sck/mosi/cs_n in the clki domain and offers
// a one-byte TX holding register and an RX data register with valid/ack.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [FRAME_BITS-1:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
  input  logic                  clki,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  rx_overrun
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic sckRise, sckFall, csRise, csFall, mosiSync;
  logic unusedSckLevel, unusedCsLevel, unusedMosiRise, unusedMosiFall;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) sckSync (
    .clk_i  (clki),
    .rst_i  (rst),
    .d_i    (sck),
    .q_o    (unusedSckLevel),
    .rise_o (sckRise),
    .fall_o (sckFall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) csSync (
    .clk_i  (clki),
    .rst_i  (rst),
    .d_i    (cs_n),
    .q_o    (unusedCsLevel),
    .rise_o (csRise),
    .fall_o (csFall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) mosiSyncInst (
    .clk_i  (clki),
    .rst_i  (rst),
    .d_i    (mosi),
    .q_o    (mosiSync),
    .rise_o (unusedMosiRise),
    .fall_o (unusedMosiFall)
  );

  spiState_e             state_q;
  logic [CNT_W-1:0]      bitCnt_q;
  logic [FRAME_BITS-1:0] shiftTx_q;
  logic [FRAME_BITS-1:0] shiftRx_q;
  logic [FRAME_BITS-1:0] txBuf_q;
  logic                  txFull_q;
  logic [FRAME_BITS-1:0] rxData_q;
  logic                  rxValid_q;
  logic                  rxOverrun_q;
  logic                  miso_q;
  logic                  misoOe_q;

  logic [FRAME_BITS-1:0] txNext_d;
  logic [FRAME_BITS-1:0] rxByte_d;

  assign txNext_d = txFull_q ? txBuf_q : IDLE_BYTE;
  assign rxByte_d = {shiftRx_q[FRAME_BITS-2:0], mosiSync};

  // Load and reload are mutually exclusive on txFull_q, so a load that lands
  // on a reload from an empty buffer is simply held for the next frame.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shiftTx_q   <= '0;
      shiftRx_q   <= '0;
      txBuf_q     <= '0;
      txFull_q    <= 1'b0;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
      rxOverrun_q <= 1'b0;
      miso_q      <= 1'b0;
      misoOe_q    <= 1'b0;
    end else begin
      if (rx_ack) begin
        rxValid_q   <= 1'b0;
        rxOverrun_q <= 1'b0;
      end
      if (tx_load && !txFull_q) begin
        txBuf_q  <= tx_data;
        txFull_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (csFall) begin
            state_q   <= SHIFT;
            shiftTx_q <= txNext_d;
            miso_q    <= txNext_d[FRAME_BITS-1];
            misoOe_q  <= 1'b1;
            bitCnt_q  <= '0;
            if (txFull_q) txFull_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (csRise) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            shiftRx_q <= '0;
            misoOe_q  <= 1'b0;
            miso_q    <= 1'b0;
          end else if (sckRise) begin
            shiftRx_q <= rxByte_d;
            bitCnt_q  <= bitCnt_q + 1'b1;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_q <= '0;
              // Without a same-cycle ack an unread byte wins over the new one.
              if (rxValid_q && !rx_ack) begin
                rxOverrun_q <= 1'b1;
              end else begin
                rxData_q  <= rxByte_d;
                rxValid_q <= 1'b1;
              end
            end
          end else if (sckFall) begin
            if (bitCnt_q != '0) begin
              shiftTx_q <= {shiftTx_q[FRAME_BITS-2:0], 1'b0};
              miso_q    <= shiftTx_q[FRAME_BITS-2];
            end else begin
              shiftTx_q <= txNext_d;
              miso_q    <= txNext_d[FRAME_BITS-1];
              if (txFull_q) txFull_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = misoOe_q;
  assign tx_ready   = ~txFull_q;
  assign rx_data    = rxData_q;
  assign rx_valid   = rxValid_q;
  assign rx_overrun = rxOverrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: acts as an SPI mode-0 master and CPU side.
module tb_spi_slave;

  localparam int HALF = 6;

  logic       clki = 1'b0;
  logic       rst = 1'b1;
  logic       sckPin = 1'b0;
  logic       mosiPin = 1'b0;
  logic       csN = 1'b1;
  logic       miso, misoOe, txReady, rxValid, rxOverrun;
  logic [7:0] txData = 8'h00;
  logic       txLoad = 1'b0;
  logic [7:0] rxData;
  logic       rxAck = 1'b0;

  int compareCount = 0;
  int mismatchCount = 0;

  logic [7:0] txExpQ[$];
  logic [7:0] rxExpQ[$];
  logic [7:0] scratch;

  spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
    .clki       (clki),
    .rst        (rst),
    .sck        (sckPin),
    .mosi       (mosiPin),
    .cs_n       (csN),
    .miso       (miso),
    .miso_oe    (misoOe),
    .tx_data    (txData),
    .tx_load    (txLoad),
    .tx_ready   (txReady),
    .rx_data    (rxData),
    .rx_valid   (rxValid),
    .rx_ack     (rxAck),
    .rx_overrun (rxOverrun)
  );

  always #5 clki = ~clki;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic loadTx(input logic [7:0] b);
    txData = b;
    txLoad = 1'b1;
    waitClk(1);
    txLoad = 1'b0;
  endtask

  task automatic ackRx();
    rxAck = 1'b1;
    waitClk(1);
    rxAck = 1'b0;
  endtask

  task automatic selectDev();
    csN = 1'b0;
    waitClk(HALF);
  endtask

  task automatic deselectDev();
    waitClk(HALF);
    csN = 1'b1;
    waitClk(HALF);
  endtask

  // Clocks nBits bits MSB first; miso is sampled just before each rising edge.
  task automatic applyStimulus(input logic [7:0] mosiByte, input int nBits,
                               output logic [7:0] misoByte);
    misoByte = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      mosiPin = mosiByte[7-i];
      waitClk(HALF);
      misoByte = {misoByte[6:0], miso};
      sckPin = 1'b1;
      waitClk(HALF);
      sckPin = 1'b0;
    end
  endtask

  task automatic runByte(input logic [7:0] mosiByte, input logic [7:0] expMiso,
                         input logic storeRx);
    logic [7:0] got;
    txExpQ.push_back(expMiso);
    if (storeRx) rxExpQ.push_back(mosiByte);
    applyStimulus(mosiByte, 8, got);
    checkOutput("txq_nonempty", 32'(txExpQ.size() != 0), 32'd1);
    if (txExpQ.size() != 0) checkOutput("miso_byte", 32'(got), 32'(txExpQ.pop_front()));
  endtask

  task automatic checkRx();
    checkOutput("rx_valid_set", 32'(rxValid), 32'd1);
    checkOutput("rxq_nonempty", 32'(rxExpQ.size() != 0), 32'd1);
    if (rxExpQ.size() != 0) checkOutput("rx_data", 32'(rxData), 32'(rxExpQ.pop_front()));
    ackRx();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_miso"}, 32'(miso), 32'd0);
    checkOutput({tag, "_miso_oe"}, 32'(misoOe), 32'd0);
    checkOutput({tag, "_tx_ready"}, 32'(txReady), 32'd1);
    checkOutput({tag, "_rx_data"}, 32'(rxData), 32'h00);
    checkOutput({tag, "_rx_valid"}, 32'(rxValid), 32'd0);
    checkOutput({tag, "_rx_overrun"}, 32'(rxOverrun), 32'd0);
  endtask

  initial begin
    waitClk(3);
    rst = 1'b0;
    waitClk(2);
    checkIdleOutputs("reset");

    // Basic frame: A5 out, 3C in
    loadTx(8'hA5);
    checkOutput("tx_ready_full", 32'(txReady), 32'd0);
    selectDev();
    checkOutput("miso_oe_sel", 32'(misoOe), 32'd1);
    runByte(8'h3C, 8'hA5, 1'b1);
    deselectDev();
    checkOutput("miso_oe_desel", 32'(misoOe), 32'd0);
    checkOutput("tx_ready_after", 32'(txReady), 32'd1);
    checkRx();
    checkOutput("rx_valid_acked", 32'(rxValid), 32'd0);

    // Back-to-back bytes in one select, only the first loaded
    loadTx(8'h81);
    selectDev();
    runByte(8'hC3, 8'h81, 1'b1);
    checkRx();
    runByte(8'h7E, 8'h00, 1'b1);
    checkRx();
    deselectDev();

    // Overrun: second frame dropped while first unread
    selectDev();
    runByte(8'h11, 8'h00, 1'b1);
    deselectDev();
    selectDev();
    runByte(8'h22, 8'h00, 1'b0);
    deselectDev();
    checkOutput("overrun_set", 32'(rxOverrun), 32'd1);
    checkRx();
    checkOutput("overrun_valid_clr", 32'(rxValid), 32'd0);
    checkOutput("overrun_clr", 32'(rxOverrun), 32'd0);

    // Aborted partial frame, then a clean frame
    selectDev();
    applyStimulus(8'hFF, 5, scratch);
    deselectDev();
    checkOutput("partial_no_valid", 32'(rxValid), 32'd0);
    checkOutput("partial_oe_off", 32'(misoOe), 32'd0);
    selectDev();
    runByte(8'h96, 8'h00, 1'b1);
    deselectDev();
    checkRx();

    // Load while full is ignored
    loadTx(8'h55);
    loadTx(8'hAA);
    selectDev();
    runByte(8'h0F, 8'h55, 1'b1);
    deselectDev();
    checkRx();
    checkOutput("tx_ready_drained", 32'(txReady), 32'd1);

    // Reset mid-frame
    loadTx(8'h33);
    selectDev();
    applyStimulus(8'hF0, 3, scratch);
    rst = 1'b1;
    #1;
    checkIdleOutputs("midreset");
    csN = 1'b1;
    sckPin = 1'b0;
    waitClk(2);
    rst = 1'b0;
    waitClk(HALF);
    checkOutput("post_reset_tx_ready", 32'(txReady), 32'd1);
    loadTx(8'hC9);
    selectDev();
    runByte(8'hA6, 8'hC9, 1'b1);
    deselectDev();
    checkRx();

    checkOutput("rxq_drained", 32'(rxExpQ.size()), 32'd0);
    checkOutput("txq_drained", 32'(txExpQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
